// File: rtl/pattern_sequencer.sv
// pattern_sequencer: colour sequence playback/check engine; define PATTERN_SEQ_WRAP_EN to loop at the end of the sequence
module pattern_sequencer #(
  parameter int COLOR_W = 2,
  parameter int MAX_LEN = 16,
  parameter int LEN_W = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load_p,
  input  logic [COLOR_W*MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]           length,
  input  logic                       next,
  input  logic                       rewind,
  input  logic                       guess_valid,
  input  logic [COLOR_W-1:0]         guess,
  output logic [COLOR_W-1:0]         compare,
  output logic                       valid,
  output logic [LEN_W-1:0]           index,
  output logic                       done,
  output logic                       hit,
  output logic                       miss
);
  typedef enum logic [1:0] {S_IDLE, S_READY, S_RUN, S_DONE} state_t;
  state_t                     state_q, state_d;
  logic [COLOR_W*MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]           len_q, len_d, index_q, index_d, index_inc;
  logic [COLOR_W-1:0]         compare_q, compare_d, cur;
  logic                       valid_q, valid_d, done_q, done_d, hit_q, hit_d, miss_q, miss_d;
  logic                       active, adv;
  // colour at the current index; colour 0 lives in the most significant slot
  always_comb begin
    cur = '0;
    for (int i = 0; i < MAX_LEN; i++)
      if (index_q == LEN_W'(i)) cur = pat_q[(MAX_LEN-i)*COLOR_W-1 -: COLOR_W];
  end
  assign active = (state_q == S_READY) || (state_q == S_RUN);
  assign index_inc = index_q + LEN_W'(1);
  // next-state: one event per cycle in priority load > rewind > guess > next
  always_comb begin
    state_d = state_q;
    pat_d = pat_q;
    len_d = len_q;
    compare_d = compare_q;
    valid_d = valid_q;
    index_d = index_q;
`ifdef PATTERN_SEQ_WRAP_EN
    done_d = 1'b0;
`else
    done_d = done_q;
`endif
    hit_d = 1'b0;
    miss_d = 1'b0;
    adv = 1'b0;
    if (load_p) begin
      pat_d = pattern;
      len_d = (length == '0) ? LEN_W'(1) : (length > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : length;
      index_d = '0;
      valid_d = 1'b0;
      done_d = 1'b0;
      state_d = S_READY;
    end else if (rewind && state_q != S_IDLE) begin
      index_d = '0;
      valid_d = 1'b0;
      done_d = 1'b0;
      state_d = S_READY;
    end else if (guess_valid && active) begin
      hit_d = (guess == cur);
      miss_d = (guess != cur);
      adv = (guess == cur);
    end else if (next && active) begin
      compare_d = cur;
      valid_d = 1'b1;
      adv = 1'b1;
    end
    if (adv) begin
      index_d = index_inc;
      state_d = S_RUN;
      if (index_inc == len_q) begin
        done_d = 1'b1;
`ifdef PATTERN_SEQ_WRAP_EN
        index_d = '0;
`else
        state_d = S_DONE;
`endif
      end
    end
  end
  // state and registered outputs, synchronous reset discards the pattern
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pat_q <= '0;
      len_q <= '0;
      compare_q <= '0;
      valid_q <= 1'b0;
      index_q <= '0;
      done_q <= 1'b0;
      hit_q <= 1'b0;
      miss_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q <= pat_d;
      len_q <= len_d;
      compare_q <= compare_d;
      valid_q <= valid_d;
      index_q <= index_d;
      done_q <= done_d;
      hit_q <= hit_d;
      miss_q <= miss_d;
    end
  end
  assign compare = compare_q;
  assign valid = valid_q;
  assign index = index_q;
  assign done = done_q;
  assign hit = hit_q;
  assign miss = miss_q;
endmodule

// File: tb/tb_pattern_sequencer.sv
// tb_pattern_sequencer: directed plus random stimulus against a behavioural model of the sequencer
module tb_pattern_sequencer;
  logic       clk = 1'b0, reset = 1'b1, load_p = 1'b0, next = 1'b0, rewind = 1'b0, guess_valid = 1'b0;
  logic [7:0] pattern = '0;
  logic [2:0] length = '0;
  logic [1:0] guess = '0;
  logic [1:0] compare;
  logic       valid, done, hit, miss;
  logic [2:0] index;
  int total = 0, bad = 0;
  int m_cols[4];
  int m_len = 0, m_pos = 0, m_cmp = 0, m_valid = 0, m_done = 0, m_hit = 0, m_miss = 0;
  bit m_loaded = 0, m_fin = 0;

  pattern_sequencer #(.COLOR_W(2), .MAX_LEN(4), .LEN_W(3)) dut (
    .clk(clk), .reset(reset), .load_p(load_p), .pattern(pattern), .length(length),
    .next(next), .rewind(rewind), .guess_valid(guess_valid), .guess(guess),
    .compare(compare), .valid(valid), .index(index), .done(done), .hit(hit), .miss(miss)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic consume();
    m_pos++;
    if (m_pos == m_len) begin
      m_done = 1;
`ifdef PATTERN_SEQ_WRAP_EN
      m_pos = 0;
`else
      m_fin = 1;
`endif
    end
  endtask

  task automatic model(input bit r, input bit ld, input logic [7:0] p, input int l, input bit nx, input bit rw, input bit gv, input int g);
    if (r) begin
      m_loaded = 0; m_fin = 0; m_len = 0; m_pos = 0; m_cmp = 0; m_valid = 0; m_done = 0; m_hit = 0; m_miss = 0;
      foreach (m_cols[i]) m_cols[i] = 0;
      return;
    end
    m_hit = 0; m_miss = 0;
`ifdef PATTERN_SEQ_WRAP_EN
    m_done = 0;
`endif
    if (ld) begin
      foreach (m_cols[i]) m_cols[i] = (p >> ((3 - i) * 2)) & 3;
      m_len = (l == 0) ? 1 : (l > 4) ? 4 : l;
      m_pos = 0; m_valid = 0; m_done = 0; m_loaded = 1; m_fin = 0;
    end else if (rw && m_loaded) begin
      m_pos = 0; m_valid = 0; m_done = 0; m_fin = 0;
    end else if (gv && m_loaded && !m_fin) begin
      if (g == m_cols[m_pos]) begin m_hit = 1; consume(); end
      else m_miss = 1;
    end else if (nx && m_loaded && !m_fin) begin
      m_cmp = m_cols[m_pos]; m_valid = 1; consume();
    end
  endtask

  task automatic step(input bit r, input bit ld, input logic [7:0] p, input logic [2:0] l, input bit nx, input bit rw, input bit gv, input logic [1:0] g);
    reset = r; load_p = ld; pattern = p; length = l; next = nx; rewind = rw; guess_valid = gv; guess = g;
    model(r, ld, p, int'(l), nx, rw, gv, int'(g));
    @(posedge clk);
    #1;
    chk("compare", compare, m_cmp);
    chk("valid", valid, m_valid);
    chk("index", index, m_pos);
    chk("done", done, m_done);
    chk("hit", hit, m_hit);
    chk("miss", miss, m_miss);
  endtask

  task automatic nx1();
    step(0, 0, 0, 0, 1, 0, 0, 0);
  endtask

  task automatic gs(input logic [1:0] g);
    step(0, 0, 0, 0, 0, 0, 1, g);
  endtask

  initial begin
    int exp_seq[4] = '{2, 1, 3, 0};
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 1, 0);
    step(0, 1, 8'b10_01_11_00, 3'd4, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      nx1();
      chk("seq_compare", compare, exp_seq[i]);
      chk("seq_index", index, i + 1);
    end
`ifndef PATTERN_SEQ_WRAP_EN
    chk("seq_done", done, 1);
    nx1();
    chk("after_done_compare", compare, 0);
    chk("after_done_index", index, 4);
`endif
    step(0, 1, 8'b10_01_11_00, 3'd4, 0, 0, 0, 0);
    gs(2); chk("g0_hit", hit, 1);
    gs(1); chk("g1_hit", hit, 1);
    gs(0); chk("g2_miss", miss, 1);
    chk("g2_index", index, 2);
    chk("g2_valid", valid, 0);
    step(0, 1, 8'b10_01_11_00, 3'd0, 0, 0, 0, 0);
    nx1();
    chk("len0_compare", compare, 2);
    chk("len0_done", done, 1);
    step(0, 1, 8'b10_01_11_00, 3'd7, 0, 0, 0, 0);
    repeat (4) nx1();
    step(0, 0, 0, 0, 0, 1, 0, 0);
    chk("rew_index", index, 0);
    chk("rew_done", done, 0);
    for (int i = 0; i < 4; i++) gs(exp_seq[i][1:0]);
    step(0, 1, 8'b01_10_00_11, 3'd3, 1, 0, 0, 0);
    chk("ldnx_valid", valid, 0);
    step(0, 0, 0, 0, 0, 1, 1, 1);
    nx1(); nx1();
    step(1, 0, 0, 0, 1, 0, 0, 0);
    nx1();
    chk("rst_compare", compare, 0);
    for (int k = 0; k < 600; k++) begin
      logic [1:0] g;
      g = ($urandom_range(0, 1) == 1 && m_loaded && !m_fin) ? 2'(m_cols[m_pos]) : 2'($urandom);
      step($urandom_range(0, 59) == 0, $urandom_range(0, 9) == 0, 8'($urandom), 3'($urandom),
           $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 2) == 0, g);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
